imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Pipelined, parametrised immediate generator for the ID stage. Accepts one fetched instruction per
//  cycle over a valid/ready handshake, decodes the format and builds the XLEN-wide immediate for every
//  RV32I/RV64I base format (I, S, B, U, J, shift-amount, CSR zimm). Results are registered and sit in a
//  2-entry skid buffer, so IF->ID backpressure has no combinational path from out_ready to in_ready.
//  Sits between the IF/ID register and the ID/EX register; the flush input is driven by the branch unit.
// PARAMETERS
//  XLEN        32   immediate/data width; legal values 32 or 64 (64 enables 6-bit shamt)
//  INST_WIDTH  32   instruction width; fixed at 32, kept as a parameter for the shared header
// PORTS
//  clk        in   1           clock; all state updates on the rising edge
//  rst_n      in   1           synchronous active-low reset
//  flush      in   1           drop all held entries; incoming beat in the same cycle is also dropped
//  in_valid   in   1           instruction beat valid
//  in_ready   out  1           stage can accept a beat (registered)
//  in_inst    in   INST_WIDTH  instruction word
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  out_imm    out  XLEN        sign/zero-extended immediate (B/J already include the <<1)
//  out_fmt    out  3           format code FMT_* (R,I,S,B,U,J,SH,CSR)
//  out_illegal out 1           opcode not in the supported set; out_imm = 0
// BEHAVIOUR
//  Reset (rst_n=0 on an edge): FSM->EMPTY, out_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_R,
//   out_illegal=0. Reset mid-operation discards held entries; no result is emitted for them.
//  Transfer: in-beat when in_valid&in_ready; out-beat when out_valid&out_ready. Latency 1 cycle:
//   a beat accepted at edge N is on out_* after edge N when the buffer was EMPTY or drained that cycle.
//  FSM (occupancy): EMPTY -in->ONE; ONE -in&!out->TWO; ONE -out&!in->EMPTY; ONE -in&out->ONE;
//   TWO -out->ONE (in_ready=0 in TWO, so no in-beat). in_ready = (state != TWO). Order strictly FIFO.
//  out_* are always driven from the head entry; unchanged while out_valid&!out_ready (stable hold).
//  flush has priority over every other event: next state EMPTY, in_ready=1, out_valid=0.
//  Decode (opcode = inst[6:0], s = inst[31], sign-extend to XLEN):
//   OP 0110011 -> FMT_R, imm 0
//   OP-IMM 0010011: funct3 001/101 -> FMT_SH, imm = zero-ext inst[24:20] (XLEN=32) or inst[25:20]
//    (XLEN=64); bit 30 (srai) never appears in imm. Other funct3 -> FMT_I, sext(inst[31:20])
//   LOAD 0000011, JALR 1100111 -> FMT_I, sext(inst[31:20])
//   STORE 0100011 -> FMT_S, sext({inst[31:25],inst[11:7]})
//   BRANCH 1100011 -> FMT_B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//   JAL 1101111 -> FMT_J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//   LUI 0110111, AUIPC 0010111 -> FMT_U, sext({inst[31:12],12'b0}) (sign-extends above bit 31 for 64)
//   SYSTEM 1110011: funct3[2]=1 -> FMT_CSR, zero-ext inst[19:15]; else FMT_I, sext(inst[31:20])
//   anything else -> out_illegal=1, FMT_R, imm 0 (still a normal beat; does not stall)
//  Decode is combinational on in_inst; only the decoded {imm,fmt,illegal} is stored (not the inst).
// STRUCTURE
//  Shared constants header const.v gains: opcode defines for LUI/AUIPC/JALR/SYSTEM, FMT_* codes (3 b).
//  One sub-module: imm_decode (purely combinational, XLEN param) -> {imm,fmt,illegal}; this block
//  instantiates it once on in_inst and owns the 2-entry buffer + FSM (head/tail regs, no RAM).
// TESTING
//  1 XLEN=32 addi x1,x0,-1 0xFFF00093 -> next cycle out_valid=1, imm 0xFFFFFFFF, fmt I
//  2 sw x1,-4(x2) 0xFE112E23 -> 0xFFFFFFFC fmt S; beq x0,x0,-8 0xFE000CE3 -> 0xFFFFFFF8 fmt B;
//    srai x1,x1,3 0x4030D093 -> 0x00000003 fmt SH
//  3 XLEN=64 lui x1,0x80000 0x800000B7 -> 0xFFFFFFFF80000000 fmt U; csrrwi 0x3401D0F3 -> zimm 0x3
//  4 out_ready=0 for 3 cycles, in_valid=1 with A,B,C -> A,B held, in_ready=0 from 2nd edge, C held
//    upstream; out_ready=1 -> A,B,C emitted in order, one per cycle, no bubble
//  5 buffer in TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted
//  6 rst_n=0 for one edge while ONE -> out_valid=0, out_imm=0; illegal opcode 0x0000007F -> illegal=1

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared constants for the immediate-generation stage: base opcodes and the
// 3-bit format codes reported alongside each immediate.
package imm_gen_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_CSR = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: purely combinational immediate decoder.
// Ports:
//   inst    in  32     instruction word
//   imm     out XLEN   sign/zero-extended immediate (B/J include the <<1)
//   fmt     out 3      format code
//   illegal out 1      opcode outside the supported base set
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    // Every immediate fits in 32 bits; build it signed at 32 and let the
    // size cast sign-extend to XLEN. Zero-extended fields carry a 0 MSB.
    logic signed [31:0] w_raw;
    logic [5:0]         w_shamt;

    always_comb begin
        w_shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
        w_raw   = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        case (inst[6:0])
            OP_OP: ;
            OP_OP_IMM: begin
                if (inst[13:12] == 2'b01) begin
                    fmt   = FMT_SH;
                    w_raw = {26'b0, w_shamt};
                end else begin
                    fmt   = FMT_I;
                    w_raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt   = FMT_I;
                w_raw = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                w_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                w_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                w_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                w_raw = {inst[31:12], 12'b0};
            end
            OP_SYSTEM: begin
                if (inst[14]) begin
                    fmt   = FMT_CSR;
                    w_raw = {27'b0, inst[19:15]};
                end else begin
                    fmt   = FMT_I;
                    w_raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            default: illegal = 1'b1;
        endcase
        imm = XLEN'(w_raw);
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: ID-stage immediate generator with a 2-entry skid buffer.
// Decodes in_inst combinationally and stores only {imm, fmt, illegal}.
// in_ready is registered, so there is no combinational out_ready->in_ready path.
// Ports:
//   clk, rst_n (sync active-low), flush (drops held entries and same-cycle beat)
//   in_valid/in_ready/in_inst     upstream handshake
//   out_valid/out_ready           downstream handshake
//   out_imm/out_fmt/out_illegal   head-entry result
//
// state | meaning
// EMPTY | no entries held
// ONE   | head entry valid
// TWO   | head and tail valid, upstream stalled
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic [2:0]            out_fmt,
    output logic                  out_illegal
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    state_e          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [XLEN-1:0] r_head_imm, r_tail_imm;
    logic [2:0]      r_head_fmt, r_tail_fmt;
    logic            r_head_ill, r_tail_ill;

    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_fmt;
    logic            w_dec_ill;
    logic            w_in_fire;
    logic            w_out_fire;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst[31:0]),
        .imm     (w_dec_imm),
        .fmt     (w_dec_fmt),
        .illegal (w_dec_ill)
    );

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head_imm  <= '0;
            r_head_fmt  <= FMT_R;
            r_head_ill  <= 1'b0;
            r_tail_imm  <= '0;
            r_tail_fmt  <= FMT_R;
            r_tail_ill  <= 1'b0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_head_imm  <= w_dec_imm;
                        r_head_fmt  <= w_dec_fmt;
                        r_head_ill  <= w_dec_ill;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_tail_imm <= w_dec_imm;
                        r_tail_fmt <= w_dec_fmt;
                        r_tail_ill <= w_dec_ill;
                        r_state    <= TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_in_fire && w_out_fire) begin
                        r_head_imm <= w_dec_imm;
                        r_head_fmt <= w_dec_fmt;
                        r_head_ill <= w_dec_ill;
                    end else if (w_out_fire) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_out_fire) begin
                        r_head_imm <= r_tail_imm;
                        r_head_fmt <= r_tail_fmt;
                        r_head_ill <= r_tail_ill;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_head_imm;
    assign out_fmt     = r_head_fmt;
    assign out_illegal = r_head_ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .INST_WIDTH(32)) d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_stage #(.XLEN(64), .INST_WIDTH(32)) d64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I,   1'b0}; // addi -1
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_S,   1'b0}; // sw -4
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, FMT_B,   1'b0}; // beq -8
        vecs[3]  = '{32'h4030D093, 32'h00000003, 64'h0000000000000003, FMT_SH,  1'b0}; // srai 3
        vecs[4]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U,   1'b0}; // lui
        vecs[5]  = '{32'h3401D0F3, 32'h00000003, 64'h0000000000000003, FMT_CSR, 1'b0}; // csrrwi
        vecs[6]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, FMT_R,   1'b1}; // illegal
        vecs[7]  = '{32'h002081B3, 32'h00000000, 64'h0000000000000000, FMT_R,   1'b0}; // add
        vecs[8]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_J,   1'b0}; // j -4
        vecs[9]  = '{32'h7FF12083, 32'h000007FF, 64'h00000000000007FF, FMT_I,   1'b0}; // lw 2047
        vecs[10] = '{32'h12345097, 32'h12345000, 64'h0000000012345000, FMT_U,   1'b0}; // auipc
        vecs[11] = '{32'h00000073, 32'h00000000, 64'h0000000000000000, FMT_I,   1'b0}; // ecall
        vecs[12] = '{32'h02109093, 32'h00000001, 64'h0000000000000021, FMT_SH,  1'b0}; // slli 33

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
        step(); step();
        chk("rst_out_valid", {63'b0, vld32}, 64'd0);
        chk("rst_in_ready",  {63'b0, rdy32}, 64'd1);
        chk("rst_imm",       {32'b0, imm32}, 64'd0);
        chk("rst_fmt",       {61'b0, fmt32}, {61'b0, FMT_R});
        chk("rst_illegal",   {63'b0, ill32}, 64'd0);
        chk("rst_out_valid64", {63'b0, vld64}, 64'd0);
        rst_n = 1'b1;
        step();

        // Streaming vectors, one per cycle, with downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            step();
            chk($sformatf("v%0d_valid32", i), {63'b0, vld32}, 64'd1);
            chk($sformatf("v%0d_imm32", i),   {32'b0, imm32}, {32'b0, vecs[i].imm32});
            chk($sformatf("v%0d_fmt32", i),   {61'b0, fmt32}, {61'b0, vecs[i].fmt});
            chk($sformatf("v%0d_ill32", i),   {63'b0, ill32}, {63'b0, vecs[i].ill});
            chk($sformatf("v%0d_imm64", i),   imm64,          vecs[i].imm64);
            chk($sformatf("v%0d_fmt64", i),   {61'b0, fmt64}, {61'b0, vecs[i].fmt});
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", {63'b0, vld32}, 64'd0);

        // Backpressure: A,B held, C stalled upstream, then drained without bubbles.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = vecs[0].inst;
        step();
        chk("bp_a_imm", {32'b0, imm32}, {32'b0, vecs[0].imm32});
        chk("bp_one_ready", {63'b0, rdy32}, 64'd1);
        in_inst = vecs[9].inst;
        step();
        chk("bp_two_ready", {63'b0, rdy32}, 64'd0);
        chk("bp_two_head", {32'b0, imm32}, {32'b0, vecs[0].imm32});
        in_inst = vecs[10].inst;
        step();
        chk("bp_hold_ready", {63'b0, rdy32}, 64'd0);
        chk("bp_hold_head", {32'b0, imm32}, {32'b0, vecs[0].imm32});
        chk("bp_hold_valid", {63'b0, vld32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_b_valid", {63'b0, vld32}, 64'd1);
        chk("bp_b_imm", {32'b0, imm32}, {32'b0, vecs[9].imm32});
        chk("bp_b_ready", {63'b0, rdy32}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_c_valid", {63'b0, vld32}, 64'd1);
        chk("bp_c_imm", {32'b0, imm32}, {32'b0, vecs[10].imm32});
        chk("bp_c_fmt", {61'b0, fmt32}, {61'b0, FMT_U});
        step();
        chk("bp_empty", {63'b0, vld32}, 64'd0);

        // Flush from TWO with a same-cycle incoming beat.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = vecs[1].inst;
        step();
        in_inst = vecs[2].inst;
        step();
        chk("fl_two_ready", {63'b0, rdy32}, 64'd0);
        flush = 1'b1; in_inst = vecs[4].inst;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {63'b0, vld32}, 64'd0);
        chk("fl_ready", {63'b0, rdy32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("fl_nothing", {63'b0, vld32}, 64'd0);

        // Reset while holding one entry.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = vecs[0].inst;
        step();
        chk("rs_one_valid", {63'b0, vld32}, 64'd1);
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rs_valid", {63'b0, vld32}, 64'd0);
        chk("rs_imm", {32'b0, imm32}, 64'd0);
        chk("rs_imm64", imm64, 64'd0);
        out_ready = 1'b1;
        step();
        chk("rs_nothing", {63'b0, vld32}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
